alu_decode_pipe: RTL and testbench

Registered, parametrised successor to the combinational ALU decoder.
- Accepts one fetched instruction per cycle with its PC and register-file operands, over a valid/ready handshake.
- Produces the ALU select and both ALU operands one cycle later, also over a valid/ready handshake.
- Adds support for AUIPC, JAL and JALR (link address), correct sign extension of I- and S-immediates, XLEN generalisation, illegal-instruction flagging, and flush.
- Sits between the decode/regfile-read stage and the execute stage.

---
 rtl/alu_decode_pipe_if.sv | 59 +++++
 rtl/alu_decode_pipe.sv | 182 ++++++++++++++++++
 tb/tb_alu_decode_pipe.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_decode_pipe_if.sv
// ALU select encodings and the upstream/downstream bundle of the registered ALU decoder.
// master drives instructions and out_ready; slave is the decode stage.
package alu_decode_pkg;
   localparam logic [4:0] ALU_NONE = 5'd0;
   localparam logic [4:0] ALU_ADD  = 5'd1;
   localparam logic [4:0] ALU_SLL  = 5'd2;
   localparam logic [4:0] ALU_SLT  = 5'd3;
   localparam logic [4:0] ALU_SLTU = 5'd4;
   localparam logic [4:0] ALU_XOR  = 5'd5;
   localparam logic [4:0] ALU_SRL  = 5'd6;
   localparam logic [4:0] ALU_SRA  = 5'd7;
   localparam logic [4:0] ALU_OR   = 5'd8;
   localparam logic [4:0] ALU_AND  = 5'd9;
   localparam logic [4:0] ALU_LUI  = 5'd10;

   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_OP_IMM = 7'h13;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_JALR   = 7'h67;
   localparam logic [6:0] OPC_JAL    = 7'h6F;
endpackage

interface alu_decode_pipe_if #(
   parameter int XLEN      = 32,
   parameter int ALU_SEL_W = 5
);
   logic                 in_valid;
   logic                 in_ready;
   logic [31:0]          in_inst;
   logic [XLEN-1:0]      in_pc;
   logic [XLEN-1:0]      in_rs1;
   logic [XLEN-1:0]      in_rs2;
   logic                 flush;
   logic                 out_valid;
   logic                 out_ready;
   logic [XLEN-1:0]      out_op1;
   logic [XLEN-1:0]      out_op2;
   logic [ALU_SEL_W-1:0] out_alu_sel;
   logic                 out_illegal;
   logic [4:0]           out_rd;
   logic [2:0]           out_funct3;
   logic [XLEN-1:0]      out_pc;

   modport master (
      output in_valid, in_inst, in_pc, in_rs1, in_rs2, flush, out_ready,
      input  in_ready, out_valid, out_op1, out_op2, out_alu_sel, out_illegal,
             out_rd, out_funct3, out_pc
   );

   modport slave (
      input  in_valid, in_inst, in_pc, in_rs1, in_rs2, flush, out_ready,
      output in_ready, out_valid, out_op1, out_op2, out_alu_sel, out_illegal,
             out_rd, out_funct3, out_pc
   );
endinterface

// File: rtl/alu_decode_pipe.sv
// One-cycle registered ALU decoder: turns an instruction plus PC/regfile operands
// into ALU select and operands, with illegal-instruction flagging and flush.
module alu_decode_pipe
   import alu_decode_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int ALU_SEL_W = 5
) (
   input  logic clk,
   input  logic rst_n,
   alu_decode_pipe_if.slave bus
);

   logic [6:0]             opcode;
   logic [2:0]             funct3;
   logic [6:0]             funct7;
   logic signed [11:0]     imm_i12;
   logic signed [11:0]     imm_s12;
   logic signed [31:0]     imm_u32;
   logic [5:0]             shamt6;
   logic signed [XLEN-1:0] imm_i;
   logic signed [XLEN-1:0] imm_s;
   logic signed [XLEN-1:0] imm_u;
   logic signed [XLEN-1:0] shamt;
   logic signed [XLEN-1:0] rs1;
   logic signed [XLEN-1:0] rs2;
   logic signed [XLEN-1:0] pc;

   assign opcode  = bus.in_inst[6:0];
   assign funct3  = bus.in_inst[14:12];
   assign funct7  = bus.in_inst[31:25];
   assign imm_i12 = bus.in_inst[31:20];
   assign imm_s12 = {bus.in_inst[31:25], bus.in_inst[11:7]};
   assign imm_u32 = {bus.in_inst[31:12], 12'b0};
   assign imm_i   = XLEN'(imm_i12);
   assign imm_s   = XLEN'(imm_s12);
   assign imm_u   = XLEN'(imm_u32);
   // RV32 shifts only use five bits; inst[25] is checked as part of legality instead
   assign shamt6  = (XLEN == 64) ? bus.in_inst[25:20] : {1'b0, bus.in_inst[24:20]};
   assign shamt   = XLEN'(shamt6);
   assign rs1     = bus.in_rs1;
   assign rs2     = bus.in_rs2;
   assign pc      = bus.in_pc;

   function automatic logic [4:0] f3_sel(input logic [2:0] f3, input logic arith);
      case (f3)
         3'b000:  f3_sel = ALU_ADD;
         3'b001:  f3_sel = ALU_SLL;
         3'b010:  f3_sel = ALU_SLT;
         3'b011:  f3_sel = ALU_SLTU;
         3'b100:  f3_sel = ALU_XOR;
         3'b101:  f3_sel = arith ? ALU_SRA : ALU_SRL;
         3'b110:  f3_sel = ALU_OR;
         default: f3_sel = ALU_AND;
      endcase
   endfunction

   logic signed [XLEN-1:0] dec_op1;
   logic signed [XLEN-1:0] dec_op2;
   logic [4:0]             dec_sel;
   logic                   dec_illegal;

   always_comb begin
      dec_op1     = '0;
      dec_op2     = '0;
      dec_sel     = ALU_NONE;
      dec_illegal = 1'b0;
      case (opcode)
         OPC_OP: begin
            dec_op1 = rs1;
            dec_sel = f3_sel(funct3, bus.in_inst[30]);
            // subtract is folded into ADD by negating rs2 (wraps at the most negative value)
            dec_op2 = (funct7 == 7'b0100000 && funct3 == 3'b000) ? -rs2 : rs2;
            dec_illegal = !((funct7 == 7'b0000000) ||
                            (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
         end
         OPC_OP_IMM: begin
            dec_op1 = rs1;
            if (funct3 == 3'b001 || funct3 == 3'b101) begin
               dec_op2     = shamt;
               dec_sel     = f3_sel(funct3, bus.in_inst[30]);
               dec_illegal = !((bus.in_inst[31:26] == 6'b000000) ||
                               (bus.in_inst[31:26] == 6'b010000 && funct3 == 3'b101)) ||
                             (XLEN == 32 && bus.in_inst[25]);
            end else begin
               dec_op2 = imm_i;
               dec_sel = f3_sel(funct3, 1'b0);
            end
         end
         OPC_LOAD: begin
            dec_op1 = rs1;
            dec_op2 = imm_i;
            dec_sel = ALU_ADD;
         end
         OPC_STORE: begin
            dec_op1 = rs1;
            dec_op2 = imm_s;
            dec_sel = ALU_ADD;
         end
         OPC_LUI: begin
            dec_op1 = imm_u;
            dec_sel = ALU_LUI;
         end
         OPC_AUIPC: begin
            dec_op1 = pc;
            dec_op2 = imm_u;
            dec_sel = ALU_ADD;
         end
         OPC_JAL, OPC_JALR: begin
            dec_op1 = pc;
            dec_op2 = XLEN'(4);
            dec_sel = ALU_ADD;
         end
         OPC_BRANCH: begin
            dec_op1 = rs1;
            dec_op2 = rs2;
            case (funct3[2:1])
               2'b00:   dec_sel = ALU_XOR;
               2'b10:   dec_sel = ALU_SLT;
               2'b11:   dec_sel = ALU_SLTU;
               default: dec_illegal = 1'b1;
            endcase
         end
         default: dec_illegal = 1'b1;
      endcase
      if (dec_illegal) begin
         dec_op1 = '0;
         dec_op2 = '0;
         dec_sel = ALU_NONE;
      end
   end

   // ---- stage p1: output register ----
   logic                   vld_p1;
   logic signed [XLEN-1:0] op1_p1;
   logic signed [XLEN-1:0] op2_p1;
   logic [ALU_SEL_W-1:0]   sel_p1;
   logic                   ill_p1;
   logic [4:0]             rd_p1;
   logic [2:0]             f3_p1;
   logic [XLEN-1:0]        pc_p1;
   logic                   accept;

   assign bus.in_ready = !vld_p1 || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         op1_p1 <= '0;
         op2_p1 <= '0;
         sel_p1 <= ALU_SEL_W'(ALU_NONE);
         ill_p1 <= 1'b0;
         rd_p1  <= '0;
         f3_p1  <= '0;
         pc_p1  <= '0;
      end else if (bus.flush) begin
         vld_p1 <= 1'b0;
      end else if (accept) begin
         vld_p1 <= 1'b1;
         op1_p1 <= dec_op1;
         op2_p1 <= dec_op2;
         sel_p1 <= ALU_SEL_W'(dec_sel);
         ill_p1 <= dec_illegal;
         rd_p1  <= bus.in_inst[11:7];
         f3_p1  <= funct3;
         pc_p1  <= bus.in_pc;
      end else if (bus.out_ready) begin
         vld_p1 <= 1'b0;
      end
   end

   assign bus.out_valid   = vld_p1;
   assign bus.out_op1     = op1_p1;
   assign bus.out_op2     = op2_p1;
   assign bus.out_alu_sel = sel_p1;
   assign bus.out_illegal = ill_p1;
   assign bus.out_rd      = rd_p1;
   assign bus.out_funct3  = f3_p1;
   assign bus.out_pc      = pc_p1;

endmodule

// File: tb/tb_alu_decode_pipe.sv
// Bench for alu_decode_pipe: reference decoder plus pipeline model checked every
// cycle, with directed vectors carrying hand-computed expectations.
module tb_alu_decode_pipe;
   import alu_decode_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   alu_decode_pipe_if #(.XLEN(32), .ALU_SEL_W(5)) bus ();
   alu_decode_pipe #(.XLEN(32), .ALU_SEL_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic [31:0] op1;
      logic [31:0] op2;
      logic [4:0]  sel;
      logic        ill;
   } exp_t;

   // Reference decoder built from the instruction-set rules, independent of the RTL layout
   function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc,
                                       input logic [31:0] rs1, input logic [31:0] rs2);
      exp_t        e;
      logic [4:0]  tbl [8];
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] immi, imms, immu;
      tbl  = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
      f3   = inst[14:12];
      f7   = inst[31:25];
      immi = 32'($signed(inst) >>> 20);
      imms = 32'(($signed(inst) >>> 25) << 5) | {27'b0, inst[11:7]};
      immu = {inst[31:12], 12'h000};
      e    = '{op1: 32'h0, op2: 32'h0, sel: ALU_NONE, ill: 1'b0};
      case (inst[6:0])
         7'h33: begin
            e.op1 = rs1; e.op2 = rs2; e.sel = tbl[f3];
            if (f7 == 7'h20 && f3 == 3'd0) e.op2 = 32'h0 - rs2;
            else if (f7 == 7'h20 && f3 == 3'd5) e.sel = ALU_SRA;
            else if (f7 != 7'h00) e.ill = 1'b1;
         end
         7'h13: begin
            e.op1 = rs1; e.sel = tbl[f3];
            if (f3 == 3'd1 || f3 == 3'd5) begin
               e.op2 = {27'b0, inst[24:20]};
               if (f7 == 7'h20 && f3 == 3'd5) e.sel = ALU_SRA;
               else if (f7 != 7'h00) e.ill = 1'b1;
            end else e.op2 = immi;
         end
         7'h03: begin e.op1 = rs1;  e.op2 = immi;  e.sel = ALU_ADD; end
         7'h23: begin e.op1 = rs1;  e.op2 = imms;  e.sel = ALU_ADD; end
         7'h37: begin e.op1 = immu; e.op2 = 32'h0; e.sel = ALU_LUI; end
         7'h17: begin e.op1 = pc;   e.op2 = immu;  e.sel = ALU_ADD; end
         7'h6F, 7'h67: begin e.op1 = pc; e.op2 = 32'd4; e.sel = ALU_ADD; end
         7'h63: begin
            e.op1 = rs1; e.op2 = rs2;
            if (f3 == 3'd0 || f3 == 3'd1) e.sel = ALU_XOR;
            else if (f3 == 3'd4 || f3 == 3'd5) e.sel = ALU_SLT;
            else if (f3 == 3'd6 || f3 == 3'd7) e.sel = ALU_SLTU;
            else e.ill = 1'b1;
         end
         default: e.ill = 1'b1;
      endcase
      if (e.ill) begin e.op1 = 32'h0; e.op2 = 32'h0; e.sel = ALU_NONE; end
      return e;
   endfunction

   // Pipeline model: one slot that fills on a transfer and empties when taken
   bit          m_valid;
   exp_t        m_e;
   logic [4:0]  m_rd;
   logic [2:0]  m_f3;
   logic [31:0] m_pc;
   bit          cmp_en = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid = 1'b0;
      end else if (bus.flush) begin
         m_valid = 1'b0;
      end else if (bus.in_valid && (!m_valid || bus.out_ready)) begin
         m_valid = 1'b1;
         m_e     = ref_decode(bus.in_inst, bus.in_pc, bus.in_rs1, bus.in_rs2);
         m_rd    = bus.in_inst[11:7];
         m_f3    = bus.in_inst[14:12];
         m_pc    = bus.in_pc;
      end else if (bus.out_ready) begin
         m_valid = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (cmp_en && rst_n) begin
         chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
         chk("in_ready", 64'(bus.in_ready), 64'(!m_valid || bus.out_ready));
         if (m_valid) begin
            chk("op1", 64'(bus.out_op1), 64'(m_e.op1));
            chk("op2", 64'(bus.out_op2), 64'(m_e.op2));
            chk("alu_sel", 64'(bus.out_alu_sel), 64'(m_e.sel));
            chk("illegal", 64'(bus.out_illegal), 64'(m_e.ill));
            chk("rd", 64'(bus.out_rd), 64'(m_rd));
            chk("funct3", 64'(bus.out_funct3), 64'(m_f3));
            chk("pc", 64'(bus.out_pc), 64'(m_pc));
         end
      end
   end

   logic [4:0] got_rd[$];
   bit         mon_en = 1'b0;
   always @(negedge clk)
      if (mon_en && bus.out_valid && bus.out_ready) got_rd.push_back(bus.out_rd);

   task automatic drive(input logic [31:0] inst, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2);
      bus.in_valid = 1'b1;
      bus.in_inst  = inst;
      bus.in_pc    = pc;
      bus.in_rs1   = rs1;
      bus.in_rs2   = rs2;
   endtask

   task automatic issue(input logic [31:0] inst, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2);
      int n = 0;
      @(posedge clk); #1;
      drive(inst, pc, rs1, rs2);
      do begin
         @(negedge clk);
         n++;
      end while (!(bus.in_ready && !bus.flush) && n < 20);
      if (n >= 20) chk("issue_timeout", 64'(n), 64'(0));
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic lit(input string name, input logic [31:0] inst, input logic [31:0] pc,
                      input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [31:0] eop1, input logic [31:0] eop2,
                      input logic [4:0] esel, input logic eill, input logic [4:0] erd);
      issue(inst, pc, rs1, rs2);
      @(negedge clk);
      chk({name, "_valid"}, 64'(bus.out_valid), 64'(1));
      chk({name, "_op1"}, 64'(bus.out_op1), 64'(eop1));
      chk({name, "_op2"}, 64'(bus.out_op2), 64'(eop2));
      chk({name, "_sel"}, 64'(bus.out_alu_sel), 64'(esel));
      chk({name, "_ill"}, 64'(bus.out_illegal), 64'(eill));
      chk({name, "_rd"}, 64'(bus.out_rd), 64'(erd));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   logic [31:0] stream [4] = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};

   initial begin
      int  i, cyc;
      bit  acc, stall_seen;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_inst   = 32'h0;
      bus.in_pc     = 32'h0;
      bus.in_rs1    = 32'h0;
      bus.in_rs2    = 32'h0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_illegal", 64'(bus.out_illegal), 64'(0));
      chk("rst_op1", 64'(bus.out_op1), 64'(0));
      chk("rst_op2", 64'(bus.out_op2), 64'(0));
      chk("rst_sel", 64'(bus.out_alu_sel), 64'(ALU_NONE));
      chk("rst_pc", 64'(bus.out_pc), 64'(0));
      @(posedge clk); #1;
      rst_n  = 1'b1;
      cmp_en = 1'b1;

      lit("addi_m1", 32'hFFF00093, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, ALU_ADD, 1'b0, 5'd1);
      lit("sub", 32'h40208033, 32'h4, 32'd5, 32'd3, 32'd5, 32'hFFFFFFFD, ALU_ADD, 1'b0, 5'd0);
      lit("sub_min", 32'h40208033, 32'h8, 32'd5, 32'h80000000, 32'd5, 32'h80000000, ALU_ADD, 1'b0, 5'd0);
      lit("sw_m4", 32'hFE112E23, 32'hC, 32'h1000, 32'h55, 32'h1000, 32'hFFFFFFFC, ALU_ADD, 1'b0, 5'd28);
      lit("lui", 32'h12345037, 32'h10, 32'h7, 32'h9, 32'h12345000, 32'h0, ALU_LUI, 1'b0, 5'd0);
      lit("auipc", 32'h00001017, 32'h100, 32'h7, 32'h9, 32'h100, 32'h1000, ALU_ADD, 1'b0, 5'd0);
      lit("jal", 32'h000000EF, 32'h200, 32'h7, 32'h9, 32'h200, 32'h4, ALU_ADD, 1'b0, 5'd1);
      lit("bltu", 32'h00006063, 32'h204, 32'h7, 32'h9, 32'h7, 32'h9, ALU_SLTU, 1'b0, 5'd0);
      lit("srai", 32'h4030D093, 32'h208, 32'hF0, 32'h0, 32'hF0, 32'h3, ALU_SRA, 1'b0, 5'd1);
      lit("opc_7f", 32'h0000007F, 32'h20C, 32'h7, 32'h9, 32'h0, 32'h0, ALU_NONE, 1'b1, 5'd0);
      lit("br_f3_2", 32'h00002063, 32'h210, 32'h7, 32'h9, 32'h0, 32'h0, ALU_NONE, 1'b1, 5'd0);
      lit("slli_b25", 32'h02009093, 32'h214, 32'h7, 32'h9, 32'h0, 32'h0, ALU_NONE, 1'b1, 5'd1);
      lit("op_xor_f7", 32'h4020C033, 32'h218, 32'h7, 32'h9, 32'h0, 32'h0, ALU_NONE, 1'b1, 5'd0);
      lit("slli_f7", 32'h40109093, 32'h21C, 32'h7, 32'h9, 32'h0, 32'h0, ALU_NONE, 1'b1, 5'd1);

      // stream of four with the consumer stalled for two cycles
      @(posedge clk); #1;
      got_rd.delete();
      mon_en     = 1'b1;
      stall_seen = 1'b0;
      i          = 0;
      cyc        = 0;
      drive(stream[0], 32'h300, 32'h0, 32'h0);
      bus.out_ready = 1'b1;
      while (i < 4 && cyc < 40) begin
         @(negedge clk);
         acc = bus.in_valid && bus.in_ready && !bus.flush;
         if (!bus.in_ready) stall_seen = 1'b1;
         @(posedge clk); #1;
         cyc++;
         if (acc) i++;
         if (i < 4) drive(stream[i], 32'h300 + 32'(4 * i), 32'h0, 32'h0);
         else bus.in_valid = 1'b0;
         bus.out_ready = !(cyc == 2 || cyc == 3);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      chk("stream_timeout", 64'(cyc >= 40), 64'(0));
      repeat (3) @(negedge clk);
      mon_en = 1'b0;
      chk("stall_in_ready_low", 64'(stall_seen), 64'(1));
      chk("stream_count", 64'(got_rd.size()), 64'(4));
      for (int k = 0; k < 4; k++)
         chk("stream_order", 64'((k < got_rd.size()) ? got_rd[k] : 5'd31), 64'(k + 1));

      // flush with a held result and a new instruction on the input
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      drive(32'h00500293, 32'h400, 32'h0, 32'h0);
      @(posedge clk); #1;
      drive(32'h00600313, 32'h404, 32'h0, 32'h0);
      bus.flush     = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("flush_pre_rd", 64'(bus.out_rd), 64'(5));
      @(posedge clk); #1;
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("flush_clears", 64'(bus.out_valid), 64'(0));
      @(negedge clk);
      chk("flush_drops", 64'(bus.out_valid), 64'(0));

      // asynchronous reset while stalled
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      drive(32'hFFF00093, 32'h500, 32'h0, 32'h0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("held_valid", 64'(bus.out_valid), 64'(1));
      #1 rst_n = 1'b0;
      #1;
      chk("rst_async_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_async_op2", 64'(bus.out_op2), 64'(0));
      @(posedge clk); #1;
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);

      cmp_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
